// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared constants and types for the radix-2 non-restoring divider.
//
//   Contents:
//     DIV_W            default operand/result width
//     S_IDLE..S_DONE   bit index of each state inside the one-hot state vector
//     div_state_t      one-hot state encoding built from those indices
//     DIV_ZERO_QUOT    quotient reported for a divide-by-zero (all ones)
//     div_cnt_last()   terminal value of the iteration counter for width n
//     DIV_CNT_LAST     terminal counter value for the default width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 32;

  // One bit per state; the index says which bit is hot.
  localparam int S_IDLE    = 0;
  localparam int S_INIT    = 1;
  localparam int S_ITER    = 2;
  localparam int S_CORRECT = 3;
  localparam int S_SIGNFIX = 4;
  localparam int S_DONE    = 5;
  localparam int S_NUM     = 6;

  typedef enum logic [S_NUM-1:0] {
    ST_IDLE    = 6'(1 << S_IDLE),
    ST_INIT    = 6'(1 << S_INIT),
    ST_ITER    = 6'(1 << S_ITER),
    ST_CORRECT = 6'(1 << S_CORRECT),
    ST_SIGNFIX = 6'(1 << S_SIGNFIX),
    ST_DONE    = 6'(1 << S_DONE)
  } div_state_t;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = '1;

  // The counter starts at 0 and the last iteration runs while it holds n-1.
  function automatic int div_cnt_last(input int n);
    return n - 1;
  endfunction

  localparam int DIV_CNT_LAST = div_cnt_last(DIV_W);

endpackage

// File: rtl/div_addsub_step.sv
// -----------------------------------------------------------------------------
// div_addsub_step
//   One combinational non-restoring division step on the {A,Q} register pair.
//   {A,Q} is shifted left by one; the shifted A then has M subtracted when the
//   incoming A is non-negative, or added when it is negative. The new quotient
//   bit is the inverted sign of the resulting A.
//
//   The add/subtract is written as a single adder with a conditionally
//   inverted operand and carry-in so a different adder can be dropped in
//   without touching the surrounding logic.
//
//   Parameters:
//     N       operand width (A is N+1 bits, Q is N bits)
//   Ports:
//     a       in   N+1  partial remainder before the step (two's complement)
//     q       in   N    partial quotient before the step
//     m       in   N+1  divisor magnitude, zero-extended
//     a_next  out  N+1  partial remainder after the step
//     q_next  out  N    partial quotient after the step
// -----------------------------------------------------------------------------
module div_addsub_step #(
  parameter int N = 32
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N:0]   m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next
);

  logic [N:0] a_shift;
  logic       sub;
  logic [N:0] operand;

  always_comb begin
    a_shift = {a[N-1:0], q[N-1]};
    sub     = ~a[N];
    // a_shift - m == a_shift + ~m + 1
    operand = sub ? ~m : m;
    a_next  = a_shift + operand + {{N{1'b0}}, sub};
    q_next  = {q[N-2:0], ~a_next[N]};
  end

endmodule

// File: rtl/radix2_nr_divider.sv
// -----------------------------------------------------------------------------
// radix2_nr_divider
//   Sequential signed integer divider using radix-2 non-restoring division,
//   one quotient bit per clock. Operands are converted to magnitudes, divided
//   unsigned on an A/Q register pair, and the signs are reapplied at the end.
//   The quotient truncates toward zero and the remainder takes the sign of the
//   dividend. Divide-by-zero reports an all-ones quotient, the dividend as the
//   remainder and raises dz.
//
//   State sequence (one-hot):
//     IDLE -> INIT -> ITER (N cycles) -> CORRECT -> SIGNFIX -> DONE -> IDLE
//
//   Build option:
//     DIV_FAST_ZERO_EN  when defined, a zero divisor seen in INIT writes the
//                       divide-by-zero results directly and jumps to DONE.
//                       Result values are the same either way.
//
//   Handshake: start is sampled only while IDLE; a start in any other state is
//   dropped. busy is high in every state but IDLE. done pulses for the single
//   DONE cycle, and quotient/remainder/dz stay stable from then until the next
//   accepted operation rewrites them.
//
//   Parameters:
//     N          operand/result width
//   Ports:
//     clk        in   1  clock, rising edge
//     rst_b      in   1  asynchronous active-low reset
//     start      in   1  operation request
//     X          in   N  dividend, two's complement
//     Y          in   N  divisor, two's complement
//     busy       out  1  operation in progress
//     done       out  1  one-cycle completion pulse
//     quotient   out  N  signed quotient
//     remainder  out  N  signed remainder
//     dz         out  1  divide-by-zero flag for the last operation
// -----------------------------------------------------------------------------
module radix2_nr_divider
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_LAST = div_cnt_last(N);
  localparam logic [N-1:0] ZERO_QUOT = {N{DIV_ZERO_QUOT[0]}};

  div_state_t state;
  div_state_t state_nxt;

  logic [N-1:0]  x_lat;
  logic [N-1:0]  y_lat;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N:0]    m;
  logic [CW-1:0] cnt;
  logic          sq;
  logic          sr;

  logic [N-1:0]  abs_x;
  logic [N-1:0]  abs_y;
  logic          y_zero;
  logic [N:0]    a_step;
  logic [N-1:0]  q_step;
  logic [N-1:0]  quot_signed;
  logic [N-1:0]  rem_signed;

  // ---------------------------------------------------------------------------
  // Operand magnitudes and sign restoration. The magnitude of the most
  // negative value is 2^(N-1), which still fits as an unsigned N-bit number.
  // ---------------------------------------------------------------------------
  always_comb begin
    abs_x       = x_lat[N-1] ? -x_lat : x_lat;
    abs_y       = y_lat[N-1] ? -y_lat : y_lat;
    y_zero      = (y_lat == '0);
    quot_signed = sq ? -q : q;
    rem_signed  = sr ? -a[N-1:0] : a[N-1:0];
  end

  div_addsub_step #(
    .N (N)
  ) u_step (
    .a      (a),
    .q      (q),
    .m      (m),
    .a_next (a_step),
    .q_next (q_step)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
`ifdef DIV_FAST_ZERO_EN
        state_nxt = y_zero ? ST_DONE : ST_ITER;
`else
        state_nxt = ST_ITER;
`endif
      end
      ST_ITER: begin
        if (cnt == CW'(CNT_LAST)) begin
          state_nxt = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        state_nxt = ST_SIGNFIX;
      end
      ST_SIGNFIX: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      x_lat     <= '0;
      y_lat     <= '0;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_lat <= X;
            y_lat <= Y;
          end
        end
        ST_INIT: begin
          a   <= '0;
          q   <= abs_x;
          m   <= {1'b0, abs_y};
          cnt <= '0;
          sq  <= x_lat[N-1] ^ y_lat[N-1];
          sr  <= x_lat[N-1];
          dz  <= y_zero;
`ifdef DIV_FAST_ZERO_EN
          if (y_zero) begin
            quotient  <= ZERO_QUOT;
            remainder <= x_lat;
          end
`endif
        end
        ST_ITER: begin
          a   <= a_step;
          q   <= q_step;
          cnt <= cnt + CW'(1);
        end
        ST_CORRECT: begin
          // A negative final partial remainder is one M short of the true one.
          if (a[N]) begin
            a <= a + m;
          end
        end
        ST_SIGNFIX: begin
          if (dz) begin
            quotient  <= ZERO_QUOT;
            remainder <= x_lat;
          end else begin
            quotient  <= quot_signed;
            remainder <= rem_signed;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_nr_divider.sv
// -----------------------------------------------------------------------------
// tb_radix2_nr_divider
//   Self-checking bench for radix2_nr_divider (N = 32). A reference model built
//   on 64-bit signed arithmetic predicts quotient, remainder, dz and the cycle
//   on which done appears; a compare process checks busy/done every cycle, the
//   results on the done cycle and the held results while idle. Directed cases
//   pin the model with literal values; a random loop covers the rest.
// -----------------------------------------------------------------------------
module tb_radix2_nr_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the currently tracked operation.
  int           cyc       = 0;
  bit           act_valid = 1'b0;
  int           act_e0    = 0;
  int           act_lat   = 0;
  logic [W-1:0] act_q     = '0;
  logic [W-1:0] act_r     = '0;
  logic         act_dz    = 1'b0;

  // Results the DUT must be holding while idle.
  logic [W-1:0] last_q  = '0;
  logic [W-1:0] last_r  = '0;
  logic         last_dz = 1'b0;

  radix2_nr_divider #(
    .N (W)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sx;
    longint sy;
    if (y == '0) begin
      q = '1;
      r = x;
      z = 1'b1;
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = W'(sx / sy);
      r  = W'(sx % sy);
      z  = 1'b0;
    end
  endfunction

  // Edges from the accepting edge E0 to the edge that enters DONE.
  function automatic int ref_lat(input logic [W-1:0] y);
`ifdef DIV_FAST_ZERO_EN
    return (y == '0) ? 1 : W + 3;
`else
    return W + 3;
`endif
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Acceptance model: sampled at each rising edge, cleared by reset.
  initial begin
    int           k;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mz;
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) begin
        act_valid = 1'b0;
      end else begin
        k   = cyc + 1;
        cyc = k;
        if (start && (!act_valid || k >= act_e0 + act_lat + 2)) begin
          ref_div(X, Y, mq, mr, mz);
          act_valid = 1'b1;
          act_e0    = k;
          act_lat   = ref_lat(Y);
          act_q     = mq;
          act_r     = mr;
          act_dz    = mz;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / compare process (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  initial begin
    bit e_busy;
    bit e_done;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
      end
      e_busy = act_valid && (cyc >= act_e0) && (cyc <= act_e0 + act_lat);
      e_done = act_valid && (cyc == act_e0 + act_lat);
      chk("busy", W'(busy), W'(e_busy));
      chk("done", W'(done), W'(e_done));
      if (e_done) begin
        chk("quotient", quotient, act_q);
        chk("remainder", remainder, act_r);
        chk("dz", W'(dz), W'(act_dz));
        last_q  = act_q;
        last_r  = act_r;
        last_dz = act_dz;
      end else if (!e_busy) begin
        chk("held_quotient", quotient, last_q);
        chk("held_remainder", remainder, last_r);
        chk("held_dz", W'(dz), W'(last_dz));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Returns at the falling edge right after the accepting edge.
  task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    X     = x;
    Y     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge of the cycle in which done must be high.
  task automatic wait_done(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = act_valid && (cyc == act_e0 + act_lat);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no completion within 200 cycles, got none expected done", name);
    end
  endtask

  task automatic run_lit(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    pulse_start(x, y);
    wait_done("lit_wait");
    chk("lit_quotient", quotient, eq);
    chk("lit_remainder", remainder, er);
    chk("lit_dz", W'(dz), W'(ez));
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = W'($urandom_range(0, 20));
      1:       v = -W'($urandom_range(1, 20));
      2:       v = 32'h8000_0000;
      3:       v = W'($urandom_range(0, 2)) - 1;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst_b = 1'b0;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    chk("reset_dz", W'(dz), '0);
    rst_b = 1'b1;

    // Directed values, including the boundary cases.
    run_lit(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_lit(-32'd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_lit(32'd100, -32'd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_lit(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_lit(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    run_lit(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_lit(32'd0, -32'd9, 32'd0, 32'd0, 1'b0);
    run_lit(-32'd3, 32'd11, 32'd0, -32'd3, 1'b0);
    run_lit(-32'd8, 32'd0, 32'hFFFF_FFFF, -32'd8, 1'b1);

    // Start during an operation is dropped; a start in the IDLE cycle right
    // after DONE is taken.
    pulse_start(32'd1000, 32'd9);
    repeat (9) @(negedge clk);
    X     = 32'd77;
    Y     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_wait");
    chk("ignore_quotient", quotient, 32'd111);
    chk("ignore_remainder", remainder, 32'd1);
    run_lit(32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

    // Asynchronous reset in the middle of the iterations.
    pulse_start(32'd12345, 32'd67);
    repeat (20) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_done", W'(done), '0);
    chk("midrst_quotient", quotient, '0);
    chk("midrst_remainder", remainder, '0);
    chk("midrst_dz", W'(dz), '0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run_lit(32'd12345, 32'd67, 32'd184, 32'd17, 1'b0);

    // Random operations, some back-to-back, some with idle gaps.
    for (int i = 0; i < 48; i++) begin
      rx = rand_operand();
      ry = rand_operand();
      pulse_start(rx, ry);
      wait_done("rand_wait");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/radix2_nr_divider.md
Name: radix2_nr_divider

Overview:
- Sequential signed integer divider, the inverse datapath of the team's radix-8 Booth multiplier.
- Same A/Q register-pair style with a shift counter and a one-hot control FSM.
- Takes a dividend and a divisor and produces quotient and remainder by non-restoring division, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic unit and is selected by the same OP decode.

Parameters:
N, 32, operand/result width in bits. Counter width is $clog2(N).

Ports:
clk  input  1  clock, rising-edge.
rst_b  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
X  input  N  dividend, two's complement.
Y  input  N  divisor, two's complement.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; results valid from this cycle on.
quotient  output  N  signed quotient, held until the next accepted start.
remainder  output  N  signed remainder, held until the next accepted start.
dz  output  1  divide-by-zero flag for the last operation; held with results.

Behaviour:
- Reset (any time, including mid-operation):
  - state=IDLE; busy=0, done=0, dz=0; quotient=0, remainder=0.
  - Internal A, Q, M and counter are cleared.
- States (one-hot): IDLE, INIT, ITER, CORRECT, SIGNFIX, DONE.
- IDLE: on start=1 at edge E0, latch X, Y → INIT. start in any other state is ignored, with no queueing.
- INIT (edge E1):
  - A(N+1 bits)=0; Q=|X|; M=|Y| zero-extended to N+1; cnt=0.
  - Latch sq=X[N-1]^Y[N-1], sr=X[N-1], dz=(Y==0).
  - |INT_MIN| = 2^(N-1) is representable as unsigned N bits.
  - Next state → ITER.
- ITER (edges E2..E(N+1)), one step per edge:
  - Shift {A,Q} left 1.
  - If old A>=0 then A=A-M, else A=A+M.
  - Set Q[0]=~A_new[N].
  - cnt++. At the edge where cnt==N-1 → CORRECT.
- CORRECT (edge E(N+2)): if A<0 then A=A+M. Next state → SIGNFIX.
- SIGNFIX (edge E(N+3)), registers outputs:
  - quotient = sq ? -Q : Q, mod 2^N.
  - remainder = sr ? -A[N-1:0] : A[N-1:0].
  - If dz: quotient = all-ones, remainder = latched X.
  - Next state → DONE.
- DONE: done=1 for exactly this cycle, busy=1 → IDLE at E(N+4). For N=32, done is high between E35 and E36.
- Boundary cases:
  - INT_MIN / -1: quotient=INT_MIN (wraps), remainder=0, dz=0.
  - 0 / Y: quotient=0, remainder=0.
  - |X| < |Y|: quotient=0, remainder=X.
  - A new start may be accepted in the IDLE cycle immediately after DONE.
- Results and dz stay stable from SIGNFIX until the next INIT overwrites them.

Optional Feature:
DIV_FAST_ZERO_EN
- Defined: when INIT detects Y==0, it writes quotient=all-ones, remainder=X and dz=1 directly, then → DONE. done is high between E1 and E2 (2-cycle total). ITER, CORRECT and SIGNFIX are skipped.
- Undefined: divide-by-zero runs the full N iterations. SIGNFIX forces the same values. Latency is identical to normal operation.
- Result values are identical in both builds; only latency differs.

Decomposition:
- Shared package div_pkg:
  - state index localparams S_IDLE..S_DONE.
  - DIV_W=32.
  - DIV_ZERO_QUOT (all-ones).
  - the counter-terminal constant.
- One natural sub-module: div_addsub_step, combinational single non-restoring step ({A,Q},M → {A',Q'}), adder-agnostic so it can later be swapped onto the team's carry-skip adder.
- FSM, counter and sign logic stay in the top module.

Test Plan:
- X=100, Y=7, start at E0 → done high E35–E36 only, quotient=14, remainder=2, dz=0, busy high E0+ through E36.
- X=-100, Y=7 → quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). X=100, Y=-7 → quotient=-14, remainder=2.
- X=0x80000000, Y=0xFFFFFFFF → quotient=0x80000000, remainder=0. X=0x80000000, Y=1 → quotient=0x80000000, remainder=0.
- X=5, Y=0 → quotient=0xFFFFFFFF, remainder=5, dz=1. done at E35 without the macro, E1 with DIV_FAST_ZERO_EN.
- Pulse start again at E10 with different operands → ignored, results match the first operation. Then start in the IDLE cycle after DONE → accepted, done 35 cycles later.
- Assert rst_b=0 at E20 mid-ITER → async clear: busy=0, done=0, outputs 0, state IDLE. Next start completes normally.
